// File: rtl/com_port_pkg.sv
// com_port_pkg
// Shared definitions for the host com-link endpoint (com_port_ctrl):
//   - state_e          : controller states, encoded as the visible `state` port
//   - DATA_W_DEF       : default com word / memory data width
//   - ADDR_W_DEF       : default memory address width
//   - NCORES_ZERO_SUB  : core mask used when the host supplies n_cores == 0
package com_port_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 12;

    // With no cores requested, core 0 still runs so the block cannot stall.
    localparam logic [3:0] NCORES_ZERO_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DUMP = 2'd3
    } state_e;

endpackage

// File: rtl/com_addr_gen.sv
// com_addr_gen
// Address counters for com_port_ctrl.
//   Load side : load_clr_i restarts at address 0; load_adv_i steps after each
//               accepted write. At the top address the counter saturates and
//               load_full_o rises, so later words are refused (no wrap).
//   Dump side : dump_clr_i restarts at index 0; dump_adv_i steps one word.
//               dump_addr_o = OUT_BASE + index modulo 2^ADDR_W;
//               dump_last_o marks index OUT_LEN-1.
// Ports: clk, rst_n (synchronous, active-low), load_clr_i, load_adv_i,
//        load_addr_o, load_full_o, dump_clr_i, dump_adv_i, dump_addr_o,
//        dump_last_o.
module com_addr_gen
    import com_port_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned OUT_BASE = 'h800,
    parameter int unsigned OUT_LEN  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_clr_i,
    input  logic              load_adv_i,
    output logic [ADDR_W-1:0] load_addr_o,
    output logic              load_full_o,
    input  logic              dump_clr_i,
    input  logic              dump_adv_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic              dump_last_o
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic              load_full_q, load_full_d;
    logic [ADDR_W-1:0] dump_idx_q,  dump_idx_d;

    // NOTE: every variable gets its hold value first, so no branch can leave
    // it unassigned and infer a latch.
    always_comb begin
        load_addr_d = load_addr_q;
        load_full_d = load_full_q;
        dump_idx_d  = dump_idx_q;

        if (load_clr_i) begin
            load_addr_d = '0;
            load_full_d = 1'b0;
        end else if (load_adv_i && !load_full_q) begin
            // The top address has just been written: flag full, keep address.
            if (load_addr_q == ADDR_MAX) begin
                load_full_d = 1'b1;
            end else begin
                load_addr_d = load_addr_q + 1'b1;
            end
        end

        if (dump_clr_i) begin
            dump_idx_d = '0;
        end else if (dump_adv_i) begin
            dump_idx_d = dump_idx_q + 1'b1;
        end
    end

    // NOTE: reset is synchronous, so it is sampled inside the clocked block
    // and is not in the sensitivity list; state updates are non-blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_addr_q <= '0;
            load_full_q <= 1'b0;
            dump_idx_q  <= '0;
        end else begin
            load_addr_q <= load_addr_d;
            load_full_q <= load_full_d;
            dump_idx_q  <= dump_idx_d;
        end
    end

    assign load_addr_o = load_addr_q;
    assign load_full_o = load_full_q;
    // ADDR_W-bit addition wraps modulo 2^ADDR_W on its own.
    assign dump_addr_o = BASE + dump_idx_q;
    assign dump_last_o = (dump_idx_q == LAST_IDX);

endmodule

// File: rtl/com_port_ctrl.sv
// com_port_ctrl
// Device-side endpoint of the 16-bit host com link. Receives the host load
// stream into shared memory from address 0, pulses cores_go, waits for the
// enabled cores, then streams OUT_LEN words from OUT_BASE back to the host.
// Optional feature macro: COM_PORT_CHECKSUM_EN appends one 16-bit wraparound
// sum word after the result words.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   com_data_in, data_write_start, data_write_done   host load stream
//   n_cores, core_done, cores_go                     core cluster control
//   mem_we, mem_addr, mem_wdata, mem_rdata           shared memory port
//   state                      0 IDLE, 1 LOAD, 2 RUN, 3 DUMP
//   com_data_out, output_write_start, output_write_done   result stream
//   load_ovf                   sticky: a load word was dropped at capacity
module com_port_ctrl
    import com_port_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned OUT_BASE = 'h800,
    parameter int unsigned OUT_LEN  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] com_data_in,
    input  logic              data_write_start,
    input  logic              data_write_done,
    input  logic [3:0]        n_cores,
    input  logic [3:0]        core_done,
    output logic              cores_go,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] com_data_out,
    output logic              output_write_start,
    output logic              output_write_done,
    output logic              load_ovf
);

    state_e            state_q, state_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [3:0]        mask_q,      mask_d;
    logic              cores_go_q,  cores_go_d;
    logic              load_ovf_q,  load_ovf_d;
    logic              rd_active_q, rd_active_d;  // dump reads still being issued
    logic              valid_q,     valid_d;      // mem_rdata is a result word
    logic              last_q,      last_d;       // ... and it is the last one

    logic              load_word, load_fire, load_drop;
    logic              run_done, enter_run, dump_finish;
    logic [ADDR_W-1:0] load_addr, dump_addr;
    logic              load_full, dump_last;

    // A load word is offered in IDLE only with start; in LOAD either strobe
    // carries a word (done alone is still a word, the final one).
    assign load_word = ((state_q == ST_IDLE) && data_write_start) ||
                       ((state_q == ST_LOAD) && (data_write_start || data_write_done));
    assign load_fire = load_word && !load_full;
    assign load_drop = load_word &&  load_full;

    // Completion is ignored during the cores_go cycle so that core_done
    // levels left over from the previous job cannot end this run early.
    assign run_done = (state_q == ST_RUN) && !cores_go_q &&
                      ((core_done & mask_q) == mask_q);

    com_addr_gen #(
        .ADDR_W  (ADDR_W),
        .OUT_BASE(OUT_BASE),
        .OUT_LEN (OUT_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_clr_i ((state_q != ST_LOAD) && !load_word),
        .load_adv_i (load_fire),
        .load_addr_o(load_addr),
        .load_full_o(load_full),
        .dump_clr_i (state_q != ST_DUMP),
        .dump_adv_i ((state_q == ST_DUMP) && rd_active_q),
        .dump_addr_o(dump_addr),
        .dump_last_o(dump_last)
    );

`ifdef COM_PORT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cks_q, cks_d;  // checksum word is on the output

    assign dump_finish = cks_q;

    always_comb begin
        sum_d = '0;
        if (state_q == ST_DUMP) begin
            sum_d = valid_q ? (sum_q + mem_rdata) : sum_q;
        end
        cks_d = last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            cks_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cks_q <= cks_d;
        end
    end

    always_comb begin
        com_data_out = '0;
        if (valid_q) begin
            com_data_out = mem_rdata;
        end else if (cks_q) begin
            com_data_out = sum_q;
        end
    end
    assign output_write_start = valid_q | cks_q;
    assign output_write_done  = cks_q;
`else
    assign dump_finish        = last_q;
    assign com_data_out       = valid_q ? mem_rdata : '0;
    assign output_write_start = valid_q;
    assign output_write_done  = last_q;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (data_write_start) state_d = data_write_done ? ST_RUN : ST_LOAD;
            ST_LOAD: if (data_write_done)  state_d = ST_RUN;
            ST_RUN:  if (run_done)         state_d = ST_DUMP;
            ST_DUMP: if (dump_finish)      state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    assign enter_run = (state_q != ST_RUN) && (state_d == ST_RUN);

    // Datapath next values.
    always_comb begin
        mem_we_d    = load_fire;
        wr_addr_d   = load_fire ? load_addr   : wr_addr_q;
        wr_data_d   = load_fire ? com_data_in : wr_data_q;
        mask_d      = mask_q;
        cores_go_d  = enter_run;
        load_ovf_d  = load_ovf_q | load_drop;
        rd_active_d = rd_active_q;
        valid_d     = (state_q == ST_DUMP) && rd_active_q;
        last_d      = (state_q == ST_DUMP) && rd_active_q && dump_last;

        if (enter_run) begin
            mask_d = (n_cores == 4'b0000) ? NCORES_ZERO_SUB : n_cores;
        end
        if ((state_q == ST_DUMP) && dump_finish) begin
            load_ovf_d = 1'b0;
        end
        if (run_done) begin
            rd_active_d = 1'b1;
        end else if ((state_q == ST_DUMP) && rd_active_q && dump_last) begin
            rd_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mask_q      <= '0;
            cores_go_q  <= 1'b0;
            load_ovf_q  <= 1'b0;
            rd_active_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mask_q      <= mask_d;
            cores_go_q  <= cores_go_d;
            load_ovf_q  <= load_ovf_d;
            rd_active_q <= rd_active_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    // The memory port is shared: DUMP drives read addresses, otherwise the
    // registered write address lines up with the registered write enable.
    assign mem_addr  = (state_q == ST_DUMP) ? dump_addr : wr_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = wr_data_q;
    assign cores_go  = cores_go_q;
    assign load_ovf  = load_ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_com_port_ctrl.sv
// tb_com_port_ctrl
// Scoreboard bench for com_port_ctrl with a small parameter set
// (ADDR_W=4, OUT_BASE=0xE, OUT_LEN=4) so capacity and read-address wrap are
// reached quickly. Also handles the COM_PORT_CHECKSUM_EN build.
module tb_com_port_ctrl;

    localparam int DW       = 16;
    localparam int AW       = 4;
    localparam int DEPTH    = 1 << AW;
    localparam int OUT_BASE = 14;
    localparam int OUT_LEN  = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] com_data_in;
    logic          data_write_start;
    logic          data_write_done;
    logic [3:0]    n_cores;
    logic [3:0]    core_done;
    logic          cores_go;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    state;
    logic [DW-1:0] com_data_out;
    logic          output_write_start;
    logic          output_write_done;
    logic          load_ovf;

    com_port_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .OUT_BASE(OUT_BASE),
        .OUT_LEN (OUT_LEN)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .com_data_in       (com_data_in),
        .data_write_start  (data_write_start),
        .data_write_done   (data_write_done),
        .n_cores           (n_cores),
        .core_done         (core_done),
        .cores_go          (cores_go),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .state             (state),
        .com_data_out      (com_data_out),
        .output_write_start(output_write_start),
        .output_write_done (output_write_done),
        .load_ovf          (load_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared memory with synchronous read; the "cores" write results through
    // their own port.
    logic [DW-1:0] mem [DEPTH];
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;

    always @(posedge clk) begin
        if (mem_we)  mem[mem_addr]  <= mem_wdata;
        if (core_we) mem[core_addr] <= core_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference: what memory should hold, from the stimulus alone.
    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
    typedef struct packed {logic [DW-1:0] data; logic last;} out_t;
    wr_t  wr_q[$];
    out_t out_q[$];
    wr_t  wr_e;
    out_t out_e;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or an
    // output word.
    logic prev_valid  = 1'b0;
    logic prev_last   = 1'b0;
    logic expect_idle = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_last   = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                check("idle_after_last", {30'd0, state}, 32'd0);
                expect_idle = 1'b0;
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", mem_addr, mem_wdata);
                end else begin
                    wr_e = wr_q.pop_front();
                    check("wr_addr", {28'd0, mem_addr}, {28'd0, wr_e.addr});
                    check("wr_data", {16'd0, mem_wdata}, {16'd0, wr_e.data});
                end
            end
            if (output_write_start) begin
                if (out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: data=0x%0h, expected no output", com_data_out);
                end else begin
                    out_e = out_q.pop_front();
                    check("out_data", {16'd0, com_data_out}, {16'd0, out_e.data});
                    check("out_done", {31'd0, output_write_done}, {31'd0, out_e.last});
                    if (out_e.last) expect_idle = 1'b1;
                end
            end else begin
                check("quiet_out", {15'd0, output_write_done, com_data_out}, 32'd0);
            end
            if (prev_valid && !prev_last && !output_write_start) begin
                checks++;
                failures++;
                $display("FAIL out_gap: output_write_start fell before the last word");
            end
            if (cores_go) check("go_only_in_run", {30'd0, state}, 32'd2);
            prev_valid = output_write_start;
            prev_last  = output_write_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random, 1: directed plan, 2: reset during dump word 2,
    // 3: checksum pattern 0xFFFF, 0x0002, 0, 0
    task automatic run_txn(input int n, input logic [3:0] nc, input int mode);
        logic [DW-1:0] w;
        logic [3:0]    mask;
        logic [3:0]    v;
        logic [DW-1:0] sum;
        int            idx;
        int            to;

        n_cores = nc;
        mask    = (nc == 4'd0) ? 4'b0001 : nc;

        for (int i = 0; i < n; i++) begin
            if (i > 0 && mode == 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    data_write_start = 1'b0;
                    data_write_done  = 1'b0;
                    com_data_in      = DW'($urandom);
                    tick();
                end
            end
            w                = (mode == 1) ? DW'(10 * (i + 1)) : DW'($urandom);
            com_data_in      = w;
            data_write_done  = (i == n - 1);
            data_write_start = (i == 0 || i != n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (i < DEPTH) begin
                wr_q.push_back('{addr: AW'(i), data: w});
                ref_mem[i] = w;
            end
            tick();
            if (i == 0 && n > 1) check("state_load", {30'd0, state}, 32'd1);
        end
        data_write_start = 1'b0;
        data_write_done  = 1'b0;
        check("state_run", {30'd0, state}, 32'd2);
        check("cores_go_pulse", {31'd0, cores_go}, 32'd1);
        check("load_ovf", {31'd0, load_ovf}, {31'd0, (n > DEPTH)});
        tick();
        check("cores_go_single", {31'd0, cores_go}, 32'd0);

        // Cores produce results in the (wrapping) result region.
        for (int j = 0; j < OUT_LEN; j++) begin
            idx        = (OUT_BASE + j) % DEPTH;
            core_we    = 1'b1;
            core_addr  = AW'(idx);
            core_wdata = (mode == 1) ? DW'(7 + j) :
                         (mode == 3) ? ((j == 0) ? 16'hFFFF : (j == 1) ? 16'h0002 : 16'h0000) :
                         DW'($urandom);
            ref_mem[idx] = core_wdata;
            tick();
        end
        core_we = 1'b0;

        // Partial completion must not end the run.
        if (mode == 1) begin
            core_done = 4'b0001;
            repeat (2) begin
                tick();
                check("wait_partial", {30'd0, state}, 32'd2);
            end
        end else begin
            repeat ($urandom_range(1, 3)) begin
                v         = 4'($urandom);
                v[0]      = 1'b0;
                core_done = v;
                tick();
                check("wait_run", {30'd0, state}, 32'd2);
                check("no_early_out", {31'd0, output_write_start}, 32'd0);
            end
        end

        sum = '0;
        for (int j = 0; j < OUT_LEN; j++) begin
            idx = (OUT_BASE + j) % DEPTH;
            sum = sum + ref_mem[idx];
`ifdef COM_PORT_CHECKSUM_EN
            out_q.push_back('{data: ref_mem[idx], last: 1'b0});
`else
            out_q.push_back('{data: ref_mem[idx], last: (j == OUT_LEN - 1)});
`endif
        end
`ifdef COM_PORT_CHECKSUM_EN
        out_q.push_back('{data: sum, last: 1'b1});
`endif

        core_done = (mode == 1) ? 4'b1011 : (4'($urandom) | mask);
        tick();
        check("state_dump", {30'd0, state}, 32'd3);
        check("latency_gap", {31'd0, output_write_start}, 32'd0);
        core_done = 4'($urandom);
        tick();
        check("first_word_latency", {31'd0, output_write_start}, 32'd1);

        if (mode == 2) begin
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            tick();
            check("rst_ctrl_outs", {21'd0, cores_go, mem_we, output_write_start, output_write_done,
                                    load_ovf, state, mem_addr}, 32'd0);
            check("rst_data_outs", {com_data_out, mem_wdata}, 32'd0);
            out_q.delete();
            tick();
            rst_n = 1'b1;
        end else begin
            to = 0;
            while (state != 2'd0 && to < 40) begin
                tick();
                to++;
            end
            check("dump_return", {30'd0, state}, 32'd0);
            check("ovf_cleared", {31'd0, load_ovf}, 32'd0);
        end
        core_done = 4'd0;
        tick();
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [3:0] nc_pick [5];

    initial begin
        nc_pick          = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        rst_n            = 1'b0;
        com_data_in      = '0;
        data_write_start = 1'b0;
        data_write_done  = 1'b0;
        n_cores          = '0;
        core_done        = '0;
        core_we          = 1'b0;
        core_addr        = '0;
        core_wdata       = '0;
        repeat (3) tick();
        check("reset_ctrl_outs", {21'd0, cores_go, mem_we, output_write_start, output_write_done,
                                  load_ovf, state, mem_addr}, 32'd0);
        check("reset_data_outs", {com_data_out, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_txn(5, 4'b0011, 1);     // directed load/run/dump plan
        run_txn(1, 4'b0000, 0);     // single word, n_cores 0 -> core 0
        run_txn(16, 4'b1111, 0);    // exactly fills memory, no overflow
        run_txn(17, 4'b0111, 0);    // one dropped word
        run_txn(4, 4'b0001, 3);     // checksum pattern
        run_txn(6, 4'b0011, 2);     // reset during dump
        run_txn(3, 4'b0011, 0);     // new load restarts at address 0
        for (int t = 0; t < 12; t++) begin
            run_txn($urandom_range(1, 20), nc_pick[$urandom_range(0, 4)], 0);
        end

        repeat (4) tick();
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("out_queue_drained", out_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
